// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-strobed word SRAM, READ_LATENCY-stage registered read path,
// access error pulse and saturating store counter. Optional macro: DMEM_WRITE_FIRST_EN.
module data_mem_responder #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_read,
  input  logic [3:0]           data_write,
  input  logic [31:0]          data_addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 data_valid,
  output logic                 access_err,
  output logic [CNT_WIDTH-1:0] store_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("data_mem_responder: READ_LATENCY must be in 1..4");
    end
  endgenerate

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] index;
  logic                  in_range;
  logic                  aligned;
  logic                  wr_req;
  logic                  wr_ok;
  logic                  rd_issue;
  logic                  err_next;
  logic [31:0]           cur_word;
  logic [31:0]           merged;
  logic [31:0]           rd_word;

  logic [31:0]             pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    index    = data_addr[ADDR_WIDTH+1:2];
    in_range = (data_addr[31:ADDR_WIDTH+2] == '0);
    // Only a full-word store must be word aligned; partial strobes address lanes inside the word.
    aligned  = (data_addr[1:0] == 2'b00) || (data_write != 4'hf);
    wr_req   = (data_write != 4'h0);
    wr_ok    = wr_req && in_range && aligned;
    cur_word = mem[index];
    merged   = cur_word;
    for (int k = 0; k < 4; k++) begin
      if (data_write[k]) merged[8*k +: 8] = data_in[8*k +: 8];
    end
`ifdef DMEM_WRITE_FIRST_EN
    rd_issue = data_read && (!wr_req || wr_ok);
    rd_word  = wr_ok ? merged : (in_range ? cur_word : 32'h0);
`else
    rd_issue = data_read && !wr_req;
    rd_word  = in_range ? cur_word : 32'h0;
`endif
    err_next = (wr_req && !wr_ok) || (rd_issue && !in_range);
  end

  // NOTE: the array is deliberately not reset; contents survive rst and only the control state clears.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (data_write[k]) mem[index][8*k +: 8] <= data_in[8*k +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= 32'h0;
      access_err  <= 1'b0;
      store_count <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      if (rd_issue) pipe_data[0] <= rd_word;
      // Data only advances behind a valid bit, so the last stage holds between completions.
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
      access_err <= err_next;
      if (wr_ok && (store_count != '1)) store_count <= store_count + CNT_WIDTH'(1);
    end
  end

  assign data_out   = pipe_data[READ_LATENCY-1];
  assign data_valid = pipe_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a latency-1 instance and a latency-3 / 2-bit-counter instance
// share stimulus; directed table, reset sequence and random traffic against a reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd  = 1'b0;
  logic [3:0]  we  = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din  = 32'h0;

  logic [31:0] out_a, out_b;
  logic        val_a, val_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_WIDTH(14), .READ_LATENCY(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .data_read(rd), .data_write(we), .data_addr(addr), .data_in(din),
    .data_out(out_a), .data_valid(val_a), .access_err(err_a), .store_count(cnt_a));

  data_mem_responder #(.ADDR_WIDTH(14), .READ_LATENCY(3), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .data_read(rd), .data_write(we), .data_addr(addr), .data_in(din),
    .data_out(out_b), .data_valid(val_b), .access_err(err_b), .store_count(cnt_b));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: word memory, issue history per edge, expected outputs.
  logic [31:0] mem_m [int];
  bit          iss_v [int];
  logic [31:0] iss_d [int];
  int          n = 0;
  logic        exp_err = 1'b0;
  int          exp_cnt_a = 0;
  int          exp_cnt_b = 0;
  logic [31:0] last_a = 32'h0;
  logic [31:0] last_b = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    iss_v.delete();
    iss_d.delete();
    exp_err   = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    last_a    = 32'h0;
    last_b    = 32'h0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    bit          in_r, al, issue;
    int          widx;
    logic [31:0] cur, nw, idata;
    n++;
    in_r  = (a[31:16] == 16'h0);
    al    = (a[1:0] == 2'b00) || (w != 4'hf);
    widx  = int'(a[15:2]);
    cur   = mem_m.exists(widx) ? mem_m[widx] : 32'h0;
    issue = 1'b0;
    idata = 32'h0;
    exp_err = 1'b0;
    if (w != 4'h0) begin
      if (in_r && al) begin
        nw = cur;
        for (int k = 0; k < 4; k++) if (w[k]) nw[8*k +: 8] = d[8*k +: 8];
        mem_m[widx] = nw;
        if (exp_cnt_a < 65535) exp_cnt_a++;
        if (exp_cnt_b < 3) exp_cnt_b++;
`ifdef DMEM_WRITE_FIRST_EN
        if (r) begin issue = 1'b1; idata = nw; end
`endif
      end else begin
        exp_err = 1'b1;
      end
    end else if (r) begin
      issue = 1'b1;
      idata = in_r ? cur : 32'h0;
      if (!in_r) exp_err = 1'b1;
    end
    iss_v[n] = issue;
    iss_d[n] = idata;
  endtask

  task automatic compare_model();
    logic ev_a, ev_b;
    ev_a = iss_v.exists(n) && iss_v[n];
    if (ev_a) last_a = iss_d[n];
    ev_b = iss_v.exists(n-2) && iss_v[n-2];
    if (ev_b) last_b = iss_d[n-2];
    check("a_valid", 32'(val_a), 32'(ev_a));
    check("a_out",   out_a,      last_a);
    check("a_err",   32'(err_a), 32'(exp_err));
    check("a_count", 32'(cnt_a), exp_cnt_a);
    check("b_valid", 32'(val_b), 32'(ev_b));
    check("b_out",   out_b,      last_b);
    check("b_err",   32'(err_b), 32'(exp_err));
    check("b_count", 32'(cnt_b), exp_cnt_b);
  endtask

  task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d);
    rd = r; we = w; addr = a; din = d;
    @(posedge clk);
    #1;
    model_step(r, w, a, d);
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_a"}, out_a, 32'h0);
    check({tag, "_val_a"}, 32'(val_a), 32'h0);
    check({tag, "_err_a"}, 32'(err_a), 32'h0);
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'h0);
    check({tag, "_out_b"}, out_b, 32'h0);
    check({tag, "_val_b"}, 32'(val_b), 32'h0);
    check({tag, "_err_b"}, 32'(err_b), 32'h0);
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'h0);
  endtask

  // Directed vector: inputs and the latency-1 instance's outputs right after that edge.
  typedef struct {
    logic        r;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic        ev;
    logic [31:0] eout;
    logic        eerr;
    int          ecnt;
  } vec_t;

  vec_t vt [19];

  initial begin
    vt[0]  = '{1'b0, 4'hf, 32'h10,       32'h12345678, 1'b0, 32'h0,        1'b0, 1};
    vt[1]  = '{1'b1, 4'h0, 32'h10,       32'h0,        1'b1, 32'h12345678, 1'b0, 1};
    vt[2]  = '{1'b0, 4'hf, 32'h20,       32'hAABBCCDD, 1'b0, 32'h12345678, 1'b0, 2};
    vt[3]  = '{1'b0, 4'h5, 32'h20,       32'h11223344, 1'b0, 32'h12345678, 1'b0, 3};
    vt[4]  = '{1'b1, 4'h0, 32'h20,       32'h0,        1'b1, 32'hAA22CC44, 1'b0, 3};
    vt[5]  = '{1'b0, 4'hf, 32'h12,       32'hFFFFFFFF, 1'b0, 32'hAA22CC44, 1'b1, 3};
    vt[6]  = '{1'b1, 4'h0, 32'h10,       32'h0,        1'b1, 32'h12345678, 1'b0, 3};
    vt[7]  = '{1'b1, 4'h0, 32'h00010000, 32'h0,        1'b1, 32'h0,        1'b1, 3};
    vt[8]  = '{1'b0, 4'hf, 32'h0,        32'h1,        1'b0, 32'h0,        1'b0, 4};
    vt[9]  = '{1'b0, 4'hf, 32'h4,        32'h2,        1'b0, 32'h0,        1'b0, 5};
    vt[10] = '{1'b0, 4'hf, 32'h8,        32'h3,        1'b0, 32'h0,        1'b0, 6};
    vt[11] = '{1'b0, 4'hf, 32'h40,       32'h0,        1'b0, 32'h0,        1'b0, 7};
    vt[12] = '{1'b1, 4'h0, 32'h0,        32'h0,        1'b1, 32'h1,        1'b0, 7};
    vt[13] = '{1'b1, 4'h0, 32'h4,        32'h0,        1'b1, 32'h2,        1'b0, 7};
    vt[14] = '{1'b1, 4'h0, 32'h8,        32'h0,        1'b1, 32'h3,        1'b0, 7};
    vt[15] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'h3,        1'b0, 7};
`ifdef DMEM_WRITE_FIRST_EN
    vt[16] = '{1'b1, 4'hf, 32'h40,       32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 8};
`else
    vt[16] = '{1'b1, 4'hf, 32'h40,       32'hDEADBEEF, 1'b0, 32'h3,        1'b0, 8};
`endif
    vt[17] = '{1'b1, 4'h0, 32'h40,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 8};
    vt[18] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 8};

    // Reset state
    #12;
    check_all_zero("reset");
    model_reset();
    #4 rst = 1'b1;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].r, vt[i].w, vt[i].a, vt[i].d);
      check($sformatf("vec%0d_valid", i), 32'(val_a), 32'(vt[i].ev));
      check($sformatf("vec%0d_out", i),   out_a,      vt[i].eout);
      check($sformatf("vec%0d_err", i),   32'(err_a), 32'(vt[i].eerr));
      check($sformatf("vec%0d_count", i), 32'(cnt_a), vt[i].ecnt);
      if (i == 9) check("b_count_saturated", 32'(cnt_b), 32'd3);
    end

    // Async reset mid-clock with two reads in flight on the latency-3 instance
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    drive(1'b1, 4'h0, 32'h20, 32'h0);
    rd = 1'b0; we = 4'h0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    n++;
    check_all_zero("rst_held");
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    check("retained_word_a", out_a, 32'h12345678);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    check("retained_word_b", out_b, 32'h12345678);
    check("retained_valid_b", 32'(val_b), 32'h1);

    // Random traffic on a pool of eight preloaded words
    for (int i = 0; i < 8; i++) drive(1'b0, 4'hf, 32'h100 + 32'(4 * i), $urandom);
    for (int c = 0; c < 600; c++) begin
      int          op;
      logic [31:0] base;
      op   = $urandom_range(0, 9);
      base = 32'h100 + 32'(4 * $urandom_range(0, 7));
      case (op)
        0, 1, 2, 3: drive(1'b1, 4'h0, base + 32'($urandom_range(0, 3)), 32'h0);
        4:          drive(1'b1, 4'h0, base | 32'h0010_0000, 32'h0);
        5, 6:       drive(1'b0, 4'($urandom_range(1, 15)), base + 32'($urandom_range(0, 3)), $urandom);
        7:          drive($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)), base | 32'h8000_0000, $urandom);
        8:          drive(1'b1, 4'($urandom_range(1, 15)), base + 32'($urandom_range(0, 3)), $urandom);
        default:    drive(1'b0, 4'h0, base, 32'h0);
      endcase
    end
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b0, 4'h0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
